fetch_iq: RTL and testbench

- Instruction queue directly downstream of the fetch stage. It captures each icache response as a {pc, inst} entry in a circular FIFO and presents entries in order to decode/dispatch.
- Drives the 2-bit queue status that fetch uses to gate new icache requests.
- Tracks outstanding fetch requests so that responses still in flight at a flush are discarded.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/iq_flush_tracker.sv | 68 ++++++
 rtl/fetch_iq.sv | 131 +++++++++++++
 tb/tb_fetch_iq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch instruction queue.
// Used by fetch_iq and iq_flush_tracker.
package fetch_pkg;

    // One queued fetch result: the PC and the instruction word returned for it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    // Queue status seen by fetch; 2'b11 is never produced.
    localparam logic [1:0] IQ_EMPTY   = 2'b00;
    localparam logic [1:0] IQ_PARTIAL = 2'b01;
    localparam logic [1:0] IQ_FULL    = 2'b10;

    // Decode an occupancy value into the fetch-facing status code.
    function automatic logic [1:0] iq_status_decode(input int unsigned cnt,
                                                    input int unsigned depth);
        if (cnt == 0) begin
            return IQ_EMPTY;
        end else if (cnt == depth) begin
            return IQ_FULL;
        end else begin
            return IQ_PARTIAL;
        end
    endfunction

endpackage

// File: rtl/iq_flush_tracker.sv
// Tracks icache requests in flight and, after a flush, how many of the
// responses still to come are stale and must be thrown away.
module iq_flush_tracker
    import fetch_pkg::*;
#(
    parameter int MAX_OUTST = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic req_issue,
    input  logic resp_valid,
    output logic resp_accept_ok
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_drop_cnt;
    logic [CW:0]   w_flush_sum;

    // Stale-response count at a flush: everything in flight, plus a request
    // issued this cycle, minus a response consumed this cycle; clamped both ways.
    always_comb begin
        w_flush_sum = {1'b0, r_out_cnt} + {{CW{1'b0}}, req_issue};
        if (resp_valid && (w_flush_sum != '0)) begin
            w_flush_sum = w_flush_sum - (CW+1)'(1);
        end
        if (w_flush_sum > {1'b0, MAX_CNT}) begin
            w_flush_sum = {1'b0, MAX_CNT};
        end
    end

    // In-flight counter: saturating up on issue, floored at zero on response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_cnt <= '0;
        end else if (req_issue && !resp_valid) begin
            if (r_out_cnt != MAX_CNT) begin
                r_out_cnt <= r_out_cnt + CW'(1);
            end
        end else if (!req_issue && resp_valid) begin
            if (r_out_cnt != '0) begin
                r_out_cnt <= r_out_cnt - CW'(1);
            end
        end
    end

    // Drop counter: reloaded from the in-flight count on every flush, then
    // drained one per response; back-to-back flushes simply reload again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_drop_cnt <= w_flush_sum[CW-1:0];
        end else if (resp_valid && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - CW'(1);
        end
    end

    assign resp_accept_ok = (r_drop_cnt == '0) && !flush;

    // Fetch must never issue more requests than the counter can track.
    a_outst_no_overrun : assert property (@(posedge clk) disable iff (!rst_n)
        !(req_issue && !resp_valid && (r_out_cnt == MAX_CNT)));

endmodule

// File: rtl/fetch_iq.sv
// Instruction queue between fetch and decode: circular FIFO of {pc, inst}
// entries with flush handling for in-flight icache responses.
// Optional macro FETCH_IQ_BYPASS_EN: when defined, a response arriving at an
// empty queue with deq_ready high is passed straight to deq_* that cycle.
module fetch_iq
    import fetch_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int MAX_OUTST = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     req_issue,
    input  logic                     resp_valid,
    input  logic [31:0]              resp_pc,
    input  logic [31:0]              resp_inst,
    input  logic                     deq_ready,
    output logic                     deq_valid,
    output logic [31:0]              deq_pc,
    output logic [31:0]              deq_inst,
    output logic [1:0]               iq_status,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    iq_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CNTW-1:0] r_count;
    logic            r_overflow;

    logic            w_accept_ok;
    logic            w_bypass;
    logic            w_deq_fire;
    logic            w_enq;
    logic            w_resp_lost;
    iq_entry_t       w_head_entry;

    iq_flush_tracker #(
        .MAX_OUTST (MAX_OUTST)
    ) u_trk (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .req_issue      (req_issue),
        .resp_valid     (resp_valid),
        .resp_accept_ok (w_accept_ok)
    );

`ifdef FETCH_IQ_BYPASS_EN
    // An eligible response meeting an empty queue and a ready consumer skips storage.
    assign w_bypass = (r_count == '0) && resp_valid && w_accept_ok && deq_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_deq_fire  = (r_count != '0) && deq_ready && !flush;
    assign w_enq       = resp_valid && w_accept_ok && !w_bypass &&
                         ((r_count != FULL_CNT) || w_deq_fire);
    assign w_resp_lost = resp_valid && w_accept_ok &&
                         (r_count == FULL_CNT) && !w_deq_fire;

    assign w_head_entry = r_mem[r_head];

`ifdef FETCH_IQ_BYPASS_EN
    assign deq_valid = (r_count != '0) || w_bypass;
    assign deq_pc    = w_bypass ? resp_pc   : w_head_entry.pc;
    assign deq_inst  = w_bypass ? resp_inst : w_head_entry.inst;
`else
    assign deq_valid = (r_count != '0);
    assign deq_pc    = w_head_entry.pc;
    assign deq_inst  = w_head_entry.inst;
`endif

    assign iq_status = iq_status_decode(32'(r_count), DEPTH);
    assign count     = r_count;
    assign overflow  = r_overflow;

    // Entry storage: written at tail on enqueue, never reset.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= '{pc: resp_pc, inst: resp_inst};
        end
    end

    // Head/tail pointers wrap naturally; a flush returns both to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_deq_fire) begin
                r_head <= r_head + AW'(1);
            end
            if (w_enq) begin
                r_tail <= r_tail + AW'(1);
            end
        end
    end

    // Occupancy: simultaneous enqueue and dequeue leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_enq && !w_deq_fire) begin
            r_count <= r_count + CNTW'(1);
        end else if (!w_enq && w_deq_fire) begin
            r_count <= r_count - CNTW'(1);
        end
    end

    // Sticky loss flag: a real response arrived with nowhere to put it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_resp_lost) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_iq.sv
// Directed bench for fetch_iq with a scoreboard: stimulus pushes expected
// dequeues, a negedge monitor pops and compares on every accepted handshake.
module tb_fetch_iq;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_issue = 1'b0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_pc = '0;
    logic [31:0] resp_inst = '0;
    logic        deq_ready = 1'b0;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_inst;
    logic [1:0]  iq_status;
    logic [3:0]  count;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    iq_entry_t sb[$];

    fetch_iq #(.DEPTH(8), .MAX_OUTST(3)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_issue  (req_issue),
        .resp_valid (resp_valid),
        .resp_pc    (resp_pc),
        .resp_inst  (resp_inst),
        .deq_ready  (deq_ready),
        .deq_valid  (deq_valid),
        .deq_pc     (deq_pc),
        .deq_inst   (deq_inst),
        .iq_status  (iq_status),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hc0de_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s act=%h t=%0t", name, act, $time);
        end
    endtask

    // One cycle of stimulus; inputs return to idle one step after the edge.
    task automatic apply(input logic rv, input logic [31:0] pc, input logic dr,
                         input logic rq, input logic fl);
        resp_valid = rv;
        resp_pc    = pc;
        resp_inst  = inst_of(pc);
        deq_ready  = dr;
        req_issue  = rq;
        flush      = fl;
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
        deq_ready  = 1'b0;
        req_issue  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        sb.push_back('{pc: pc, inst: inst_of(pc)});
    endtask

    // Monitor: every accepted dequeue must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && deq_valid && deq_ready && !flush) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_deq act_pc=%h exp=none", deq_pc);
            end else begin
                iq_entry_t e;
                e = sb.pop_front();
                chk("deq_pc", deq_pc, e.pc);
                chk("deq_inst", deq_inst, e.inst);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_status", 32'(iq_status), 32'(IQ_EMPTY));
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Fill the queue with deq_ready low.
        for (int k = 0; k < 8; k++) begin
            pc = 32'h1eceb000 + 32'(4 * k);
            if (k != 0) push_exp(pc);
            apply(1'b1, pc, 1'b0, 1'b0, 1'b0);
            if (k == 0) chk("status_partial", 32'(iq_status), 32'(IQ_PARTIAL));
        end
        chk("full_count", 32'(count), 32'd8);
        chk("full_status", 32'(iq_status), 32'(IQ_FULL));

        // Full queue: simultaneous dequeue and response keeps it full.
        sb.push_front('{pc: 32'h1eceb000, inst: inst_of(32'h1eceb000)});
        push_exp(32'h1eceb020);
        apply(1'b1, 32'h1eceb020, 1'b1, 1'b0, 1'b0);
        chk("full_swap_count", 32'(count), 32'd8);
        chk("full_swap_head", deq_pc, 32'h1eceb004);
        chk("full_swap_ovf", 32'(overflow), 32'd0);

        // Full queue, no dequeue: response is lost.
        apply(1'b1, 32'h1eceb024, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Drain in order.
        for (int k = 0; k < 8; k++) apply(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_status", 32'(iq_status), 32'(IQ_EMPTY));

        // Asynchronous reset clears overflow immediately.
        rst_n = 1'b0;
        #1;
        chk("async_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Flush with two requests in flight; stale responses are dropped.
        apply(1'b1, 32'h1eceb0a0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 32'h1eceb0a4, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd2);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_deq_valid", 32'(deq_valid), 32'd0);
        chk("flush_drop", 32'(u_dut.u_trk.r_drop_cnt), 32'd2);
        apply(1'b1, 32'h1eceb0f8, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 32'h1eceb0fc, 1'b0, 1'b0, 1'b0);
        chk("drop_count", 32'(count), 32'd0);
        push_exp(32'h1eceb100);
        apply(1'b1, 32'h1eceb100, 1'b0, 1'b0, 1'b0);
        chk("post_drop_count", 32'(count), 32'd1);
        chk("post_drop_pc", deq_pc, 32'h1eceb100);
        apply(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("post_drop_drain", 32'(count), 32'd0);

        // Flush coincident with a request and a response, one in flight.
        apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 32'h1eceb140, 1'b0, 1'b1, 1'b1);
        chk("coinc_drop", 32'(u_dut.u_trk.r_drop_cnt), 32'd1);
        chk("coinc_count", 32'(count), 32'd0);
        apply(1'b1, 32'h1eceb144, 1'b0, 1'b0, 1'b0);
        chk("coinc_drop_done", 32'(u_dut.u_trk.r_drop_cnt), 32'd0);
        chk("coinc_count2", 32'(count), 32'd0);

        // Pointer wrap: 20 streaming enqueue/dequeue pairs.
        for (int k = 0; k < 20; k++) begin
            pc = 32'h1eceb300 + 32'(4 * k);
            push_exp(pc);
            apply(1'b1, pc, 1'b1, 1'b0, 1'b0);
        end
        apply(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("wrap_count", 32'(count), 32'd0);
        chk("wrap_status", 32'(iq_status), 32'(IQ_EMPTY));
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

        // Empty-queue response with a ready consumer.
        push_exp(32'h1eceb400);
        resp_valid = 1'b1;
        resp_pc    = 32'h1eceb400;
        resp_inst  = inst_of(32'h1eceb400);
        deq_ready  = 1'b1;
        @(negedge clk);
`ifdef FETCH_IQ_BYPASS_EN
        chk("byp_same_valid", 32'(deq_valid), 32'd1);
        chk("byp_same_pc", deq_pc, 32'h1eceb400);
`else
        chk("nobyp_same_valid", 32'(deq_valid), 32'd0);
`endif
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
`ifdef FETCH_IQ_BYPASS_EN
        chk("byp_count", 32'(count), 32'd0);
`else
        chk("nobyp_next_valid", 32'(deq_valid), 32'd1);
        chk("nobyp_count", 32'(count), 32'd1);
`endif
        @(posedge clk);
        #1;
        deq_ready = 1'b0;
        chk("final_count", 32'(count), 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
